ofmap_collector: RTL and testbench
==================================

OFMAP_COLLECTOR -- requirements
Module: ofmap_collector

Interface
REQ-001 Parameter PKT_W, default 45: width of an inbound spike-row packet.
REQ-002 Parameter NODE_W, default 4: source PE node-id width.
REQ-003 Parameter OUT_DIM, default 21: output feature-map rows and columns (IFMAP_SIZE 25 minus filter 5 plus 1).
REQ-004 Parameter TSTEPS, default 2: number of timesteps stored.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port in_valid / in_ready / in_data, input / output / input, 1 / 1 / PKT_W: spike-row packets arriving from the mesh output router.
REQ-008 Port ack_valid / ack_ready / ack_data, output / input / output, 1 / 1 / 10: write-acknowledge packet sent back toward the source PE.
REQ-009 Port rd_en / rd_ts / rd_row, input / input / input, 1 / 1 / 5: host read request selecting a timestep and a row.
REQ-010 Port rd_valid / rd_data, output / output, 1 / OUT_DIM: registered read response.
REQ-011 Port done / err_dup / err_range, outputs, 1 each: all rows received / duplicate row seen / row index out of range.

Function
REQ-012 Inbound field layout: [44:41] src node, [40] timestep, [39:35] row, [34:14] 21 spike bits; bits [13:0] are ignored.
REQ-013 The FSM has exactly three states, IDLE, WRITE and ACK; in_ready SHALL be 1 only in IDLE.
REQ-014 A transfer occurs when in_valid and in_ready are both high at a clock edge; on that edge the fields are latched and the FSM goes IDLE->WRITE.
REQ-015 In WRITE, a packet with row < OUT_DIM SHALL write its 21 spike bits into memory[ts][row] and set written[ts][row]; the FSM then goes to ACK.
REQ-016 A packet with row >= OUT_DIM SHALL NOT write memory, SHALL set sticky err_range, and SHALL still be acknowledged.
REQ-017 A packet targeting a row whose written bit is already set SHALL overwrite the data and SHALL set sticky err_dup.
REQ-018 In ACK, ack_valid=1 and ack_data={row[4:0], src[3:0], ts}; ack_data SHALL be held stable until ack_ready is sampled high, then the FSM goes ACK->IDLE.
REQ-019 The minimum packet-to-packet interval is 3 cycles: accept edge N, ack visible in cycle N+2 (after the WRITE cycle), in_ready high again in cycle N+3 if ack_ready was high in cycle N+2.
REQ-020 done SHALL go to 1 in the cycle after the written count reaches TSTEPS*OUT_DIM (42), and SHALL stay at 1 until reset; packets keep being accepted after done.
REQ-021 rd_en sampled high SHALL give rd_valid=1 and rd_data=memory[rd_ts][rd_row] in the next cycle; otherwise rd_valid=0.
REQ-022 A read out of range SHALL return rd_data=0.
REQ-023 A read and a WRITE to the same entry in the same cycle SHALL return the old data.
REQ-024 The written count SHALL saturate at 42, and duplicate writes SHALL NOT increment it.

Reset
REQ-025 While rst=1: FSM->IDLE; in_ready, ack_valid, rd_valid, done, err_dup and err_range all 0; all written bits cleared; count 0.
REQ-026 Memory contents are not cleared by reset; they are unreadable as valid data until rewritten.
REQ-027 rst asserted mid-packet (in WRITE or ACK) SHALL abort the packet with no ack; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro OFMAP_COLLECTOR_SPIKE_CNT_EN defined: extra outputs spike_cnt0 and spike_cnt1 (10 bits each) accumulate the popcount of spike bits written per timestep, including duplicate overwrites; both reset to 0.
REQ-029 Macro OFMAP_COLLECTOR_SPIKE_CNT_EN undefined: those ports and the counter logic are absent; all other behaviour is identical.

Verification
REQ-030 Bench SHALL cover: reset, then packet src=5, ts=1, row=3, spikes=0x155555 -> ack_data={3,5,1} two cycles after accept; a later read (1,3) returns 0x155555.
REQ-031 Bench SHALL cover: all 42 distinct (ts,row) packets -> done=1 one cycle after the 42nd WRITE, err_dup=0, err_range=0.
REQ-032 Bench SHALL cover: row=25 packet -> err_range=1, ack still issued, no memory change.
REQ-033 Bench SHALL cover: same (0,7) sent twice -> err_dup=1, count unchanged, the second data is read back.
REQ-034 Bench SHALL cover: ack_ready held low 5 cycles -> ack_data stable and in_ready=0 throughout; accept resumes after the ack.
REQ-035 Bench SHALL cover: rst pulsed during ACK -> no ack completes, done=0, in_ready=1 in the first cycle after rst falls.

Source files
------------

// File: rtl/ofmap_collector.sv
// ofmap_collector: collects output-feature-map spike rows from the mesh output
// router, stores them per timestep, acknowledges each packet back toward the
// source PE, and serves registered host reads.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   in_valid / in_ready / in_data     inbound spike-row packet
//                                     fields: src node, timestep, row, spikes;
//                                     the low bits below the spikes are ignored
//   ack_valid / ack_ready / ack_data  write-acknowledge {row, src, ts}
//   rd_en / rd_ts / rd_row            host read request
//   rd_valid / rd_data                registered read response, one cycle later
//   done                              every (ts,row) entry written at least once
//   err_dup / err_range               sticky: duplicate row / row out of range
//   spike_cnt0 / spike_cnt1           per-timestep spike popcount totals
//                                     (present only with OFMAP_COLLECTOR_SPIKE_CNT_EN)
//   dbg_state                         current FSM state (IDLE=0, WRITE=1, ACK=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the sender holds valid and data stable until that edge.
//
// Optional feature macro: OFMAP_COLLECTOR_SPIKE_CNT_EN.
module ofmap_collector #(
  parameter int PKT_W   = 45,
  parameter int NODE_W  = 4,
  parameter int OUT_DIM = 21,
  parameter int TSTEPS  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PKT_W-1:0]   in_data,
  output logic               ack_valid,
  input  logic               ack_ready,
  output logic [9:0]         ack_data,
  input  logic               rd_en,
  input  logic               rd_ts,
  input  logic [4:0]         rd_row,
  output logic               rd_valid,
  output logic [OUT_DIM-1:0] rd_data,
  output logic               done,
  output logic               err_dup,
  output logic               err_range,
`ifdef OFMAP_COLLECTOR_SPIKE_CNT_EN
  output logic [9:0]         spike_cnt0,
  output logic [9:0]         spike_cnt1,
`endif
  output logic [1:0]         dbg_state
);

  localparam int DEPTH   = TSTEPS * OUT_DIM;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int SRC_LSB = PKT_W - NODE_W;
  localparam int TS_BIT  = SRC_LSB - 1;
  localparam int ROW_LSB = TS_BIT - 5;
  localparam int SPK_LSB = ROW_LSB - OUT_DIM;
  localparam logic [4:0] ROW_LIM = 5'(OUT_DIM);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, ACK = 2'd2} state_t;

  state_t state, state_next;

  logic [NODE_W-1:0]  src_q;
  logic               ts_q;
  logic [4:0]         row_q;
  logic [OUT_DIM-1:0] spk_q;

  logic [OUT_DIM-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   written;
  logic [CW-1:0]      count, count_next;

  logic          accept;
  logic          wr_in_range, do_write, count_inc;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          rd_ok, rd_hit;
  logic          unused_bits;

  // Bits below the spike field carry nothing for this block.
  assign unused_bits = ^in_data[SPK_LSB-1:0];

  // Ready/valid outputs are forced low while reset is held, even before the
  // first reset edge has returned the FSM to IDLE.
  assign in_ready  = (state == IDLE) && !rst;
  assign ack_valid = (state == ACK) && !rst;
  assign accept    = in_valid && in_ready;
  assign ack_data  = {row_q, src_q[3:0], ts_q};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = WRITE;
      WRITE:   state_next = ACK;
      ACK:     if (ack_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      src_q <= in_data[SRC_LSB +: NODE_W];
      ts_q  <= in_data[TS_BIT];
      row_q <= in_data[ROW_LSB +: 5];
      spk_q <= in_data[SPK_LSB +: OUT_DIM];
    end
  end

  // Flat storage: entry (ts,row) lives at ts*OUT_DIM + row. The range check
  // keeps an out-of-range row from aliasing into the next timestep.
  assign wr_in_range = (row_q < ROW_LIM);
  assign wr_idx      = AW'(ts_q) * AW'(OUT_DIM) + AW'(row_q);
  assign do_write    = (state == WRITE) && wr_in_range && !rst;

  assign rd_ok  = (rd_row < ROW_LIM) && (int'(rd_ts) < TSTEPS);
  assign rd_idx = AW'(rd_ts) * AW'(OUT_DIM) + AW'(rd_row);
  // Entries not written since reset read back as zero.
  assign rd_hit = rd_ok ? written[rd_idx] : 1'b0;

  assign count_inc  = do_write && !written[wr_idx] && (count != CW'(DEPTH));
  assign count_next = count + CW'(count_inc);

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_idx] <= spk_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      written   <= '0;
      count     <= '0;
      done      <= 1'b0;
      err_dup   <= 1'b0;
      err_range <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_valid <= rd_en;
      // Read uses the pre-edge memory, so a same-cycle write returns old data.
      rd_data  <= (rd_en && rd_hit) ? mem[rd_idx] : '0;
      if (state == WRITE) begin
        if (wr_in_range) begin
          if (written[wr_idx]) err_dup <= 1'b1;
          written[wr_idx] <= 1'b1;
        end else begin
          err_range <= 1'b1;
        end
      end
      count <= count_next;
      done  <= done || (count_next == CW'(DEPTH));
    end
  end

`ifdef OFMAP_COLLECTOR_SPIKE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_cnt0 <= '0;
      spike_cnt1 <= '0;
    end else if (do_write) begin
      if (ts_q) spike_cnt1 <= spike_cnt1 + 10'($countones(spk_q));
      else      spike_cnt0 <= spike_cnt0 + 10'($countones(spk_q));
    end
  end
`endif

endmodule

// File: tb/tb_ofmap_collector.sv
// Self-checking bench for ofmap_collector with a behavioural model of the
// stored feature map, written-entry set and sticky flags.
module tb_ofmap_collector;
  localparam int PKT_W   = 45;
  localparam int OUT_DIM = 21;
  localparam int TSTEPS  = 2;
  localparam int DEPTH   = TSTEPS * OUT_DIM;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [PKT_W-1:0]   in_data = '0;
  logic               ack_valid;
  logic               ack_ready = 1'b1;
  logic [9:0]         ack_data;
  logic               rd_en = 1'b0;
  logic               rd_ts = 1'b0;
  logic [4:0]         rd_row = '0;
  logic               rd_valid;
  logic [OUT_DIM-1:0] rd_data;
  logic               done, err_dup, err_range;
  logic [1:0]         dbg_state;
`ifdef OFMAP_COLLECTOR_SPIKE_CNT_EN
  logic [9:0]         spike_cnt0, spike_cnt1;
`endif

  ofmap_collector dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_data(ack_data),
    .rd_en(rd_en), .rd_ts(rd_ts), .rd_row(rd_row),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err_dup(err_dup), .err_range(err_range),
`ifdef OFMAP_COLLECTOR_SPIKE_CNT_EN
    .spike_cnt0(spike_cnt0), .spike_cnt1(spike_cnt1),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [OUT_DIM-1:0] m_mem [TSTEPS][OUT_DIM];
  bit                 m_wr  [TSTEPS][OUT_DIM];
  int                 m_cnt;
  bit                 m_done, m_dup, m_rng;
  int                 m_sc  [TSTEPS];
  logic [9:0]         exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < TSTEPS; t++) begin
      m_sc[t] = 0;
      for (int r = 0; r < OUT_DIM; r++) m_wr[t][r] = 1'b0;
    end
    m_cnt = 0; m_done = 0; m_dup = 0; m_rng = 0;
  endtask

  function automatic logic [OUT_DIM-1:0] model_read(input int ts, input int row);
    if (row < OUT_DIM && m_wr[ts][row]) return m_mem[ts][row];
    return '0;
  endfunction

  task automatic model_write(input int ts, input int row, input logic [OUT_DIM-1:0] spk);
    if (row >= OUT_DIM) begin
      m_rng = 1;
    end else begin
      if (m_wr[ts][row]) m_dup = 1;
      else begin
        m_wr[ts][row] = 1;
        if (m_cnt < DEPTH) m_cnt++;
      end
      m_mem[ts][row] = spk;
      m_sc[ts] = (m_sc[ts] + $countones(spk)) % 1024;
    end
    if (m_cnt == DEPTH) m_done = 1;
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_ack_valid", ack_valid, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_err_dup", err_dup, 0);
    check("rst_err_range", err_range, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
  endtask

  task automatic send_pkt(input int src, input int ts, input int row,
                          input logic [OUT_DIM-1:0] spk, input int stall, input bit collide);
    int guard;
    logic [OUT_DIM-1:0] old;
    logic [9:0] held;
    in_data  = {4'(src), 1'(ts), 5'(row), spk, 14'($urandom)};
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    ack_ready = (stall == 0);
    @(negedge clk);                       // WRITE cycle
    in_valid = 1'b0;
    check("write_in_ready", in_ready, 0);
    check("write_ack_valid", ack_valid, 0);
    old = model_read(ts, row);
    if (collide) begin
      rd_en = 1'b1; rd_ts = 1'(ts); rd_row = 5'(row);
    end
    @(negedge clk);                       // ACK cycle
    if (collide) begin
      rd_en = 1'b0;
      check("collide_rd_valid", rd_valid, 1);
      check("collide_old_data", rd_data, old);
    end
    model_write(ts, row, spk);
    exp_q.push_back({5'(row), 4'(src), 1'(ts)});
    check("ack_valid", ack_valid, 1);
    check("ack_data", ack_data, exp_q.pop_front());
    check("done", done, m_done);
    check("err_dup", err_dup, m_dup);
    check("err_range", err_range, m_rng);
`ifdef OFMAP_COLLECTOR_SPIKE_CNT_EN
    check("spike_cnt0", spike_cnt0, m_sc[0]);
    check("spike_cnt1", spike_cnt1, m_sc[1]);
`endif
    held = {5'(row), 4'(src), 1'(ts)};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_ack_valid", ack_valid, 1);
      check("stall_ack_data", ack_data, held);
      check("stall_in_ready", in_ready, 0);
    end
    ack_ready = 1'b1;
    @(negedge clk);
    check("after_ack_in_ready", in_ready, 1);
    check("after_ack_valid", ack_valid, 0);
  endtask

  task automatic do_read(input int ts, input int row);
    rd_en = 1'b1; rd_ts = 1'(ts); rd_row = 5'(row);
    @(negedge clk);
    rd_en = 1'b0;
    check("rd_valid", rd_valid, 1);
    check("rd_data", rd_data, model_read(ts, row));
    @(negedge clk);
    check("rd_valid_idle", rd_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int order [$];
    int j, tmp;
    model_reset();
    @(negedge clk);
    do_reset();

    // Directed first packet and read-back.
    send_pkt(5, 1, 3, 21'h155555, 0, 0);
    do_read(1, 3);
    check("read_1_3_literal", rd_data, 0);  // rd_data returns to 0 when idle
    do_read(0, 0);
    do_read(1, 25);

    // All 42 distinct entries in random order.
    do_reset();
    for (int i = 0; i < DEPTH; i++) order.push_back(i);
    for (int i = DEPTH - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    foreach (order[k])
      send_pkt($urandom_range(0, 15), order[k] / OUT_DIM, order[k] % OUT_DIM,
               21'($urandom), 0, 1'($urandom_range(0, 1)));
    check("full_done", done, 1);
    check("full_err_dup", err_dup, 0);
    check("full_err_range", err_range, 0);
    for (int i = 0; i < 6; i++) do_read($urandom_range(0, 1), $urandom_range(0, 20));

    // Out-of-range row: ts0 row25 would alias to (1,4) if unguarded.
    send_pkt(9, 0, 25, 21'h1FFFFF, 0, 0);
    do_read(1, 4);
    do_read(0, 20);

    // ack_ready held low for five cycles.
    send_pkt(3, 0, 11, 21'($urandom), 5, 0);
    do_read(0, 11);

    // Duplicate entry does not advance the written count.
    do_reset();
    send_pkt(1, 0, 7, 21'h0ABCDE, 0, 0);
    send_pkt(2, 0, 7, 21'h154321, 0, 1);
    do_read(0, 7);
    for (int i = 0; i < DEPTH; i++)
      if (i != 7) send_pkt($urandom_range(0, 15), i / OUT_DIM, i % OUT_DIM,
                           21'($urandom), 0, 0);

    // Random mix, including out-of-range rows and stalls.
    for (int i = 0; i < 25; i++) begin
      send_pkt($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 31),
               21'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) do_read($urandom_range(0, 1), $urandom_range(0, 31));
    end

    // Reset while the ack is pending: the ack never completes.
    in_data = {4'd6, 1'b1, 5'd2, 21'h0F0F0F, 14'd0};
    in_valid = 1'b1;
    ack_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_ack_valid", ack_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ack_valid", ack_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b0;
    ack_ready = 1'b1;
    model_reset();
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_ack_valid", ack_valid, 0);
    check("abort_done", done, 0);
    do_read(1, 2);
    send_pkt(7, 1, 2, 21'h0AAAAA, 0, 0);
    do_read(1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
